// File: rtl/sk6812_strip_peripheral_if.sv
// sk6812_strip_peripheral_if: 6502-style register bus for the strip peripheral.
// i_addr/i_data/i_en/i_rw driven by the master, o_data returned by the slave.
interface sk6812_strip_peripheral_if;
   logic [2:0] i_addr;
   logic [7:0] i_data;
   logic [7:0] o_data;
   logic       i_en;
   logic       i_rw;

   modport master (
      output i_addr, i_data, i_en, i_rw,
      input  o_data
   );

   modport slave (
      input  i_addr, i_data, i_en, i_rw,
      output o_data
   );
endinterface

// File: rtl/sk6812_strip_peripheral.sv
// sk6812_strip_peripheral: frame-buffered SK6812 strip serialiser on a byte bus.
// Ports: i_clk, i_reset_n (sync, low), bus (slave), o_led_data, o_busy.
module sk6812_strip_peripheral #(
   parameter int NUM_LEDS          = 8,
   parameter int BYTES_PER_LED     = 4,
   parameter int CLOCK_DIV_DEFAULT = 1,
   parameter int BIT_TICKS         = 12,
   parameter int T0H_TICKS         = 3,
   parameter int T1H_TICKS         = 6,
   parameter int RESET_TICKS       = 800
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   sk6812_strip_peripheral_if.slave bus,
   output logic                     o_led_data,
   output logic                     o_busy
);
   localparam int DEPTH = NUM_LEDS * BYTES_PER_LED;
   localparam int AW    = $clog2(DEPTH);
   localparam int NBW   = $clog2(DEPTH + 1);
   localparam int TW    = $clog2(RESET_TICKS + BIT_TICKS + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, HIGH, LOW, GAP
   } state_t;

   state_t state_q, state_d;

   logic [7:0]     mem [DEPTH];
   logic [7:0]     rd_q;
   logic [7:0]     rd_mux;
   logic [AW-1:0]  ptr_q, ptr_wrap, idx_ptr;
   logic [AW-1:0]  eng_q;
   logic [7:0]     div_q, div_f, count_q, pre_q;
   logic [8:0]     pix;
   logic [NBW-1:0] nb_cfg, nb_f, nb_use;
   logic [TW-1:0]  tcnt_q, th_m1, tl_m1;
   logic [7:0]     sh_q;
   logic [2:0]     bit_q;
   logic           auto_q, last_q, ld_ph_q;
   logic           wr, rd, wr_data, start;
   logic           tick, hi_end, lo_end, gap_end;
   logic           fetch, last_nx;

   assign wr      = bus.i_en && !bus.i_rw;
   assign rd      = bus.i_en && bus.i_rw;
   assign wr_data = wr && bus.i_addr == 3'd3;
   assign start   = wr && bus.i_addr == 3'd0
                 && bus.i_data[0] && state_q == IDLE;

   assign tick  = pre_q == div_f;
   assign th_m1 = sh_q[7] ? TW'(T1H_TICKS - 1)
                          : TW'(T0H_TICKS - 1);
   assign tl_m1 = sh_q[7] ? TW'(BIT_TICKS - T1H_TICKS - 1)
                          : TW'(BIT_TICKS - T0H_TICKS - 1);

   assign hi_end  = state_q == HIGH && tick && tcnt_q == th_m1;
   assign lo_end  = state_q == LOW && tick && tcnt_q == tl_m1;
   assign gap_end = state_q == GAP && tick
                 && tcnt_q == TW'(RESET_TICKS - 1);

   // Repeat frames pick up COUNT afresh; others use the latched size.
   assign nb_use  = state_q == GAP ? nb_cfg : nb_f;
   assign last_nx = NBW'(eng_q) + NBW'(1) == nb_use;

   assign fetch = (state_q == LOAD && ld_ph_q)
               || (lo_end && bit_q == 3'd0 && !last_q)
               || (gap_end && auto_q);

   assign ptr_wrap = ptr_q == AW'(DEPTH - 1) ? '0 : ptr_q + AW'(1);
   assign idx_ptr  = int'(bus.i_data) < NUM_LEDS
                   ? AW'(int'(bus.i_data) * BYTES_PER_LED) : '0;

   always_comb begin
      pix = {1'b0, count_q};
      if (count_q == 8'd0 || pix > 9'(NUM_LEDS))
         pix = 9'(NUM_LEDS);
      nb_cfg = NBW'(int'(pix) * BYTES_PER_LED);
   end

   always_comb begin
      rd_mux = 8'd0;
      case (bus.i_addr)
         3'd0:    rd_mux = {6'd0, auto_q, o_busy};
         3'd1:    rd_mux = div_q;
         3'd2:    rd_mux = 8'(int'(ptr_q) / BYTES_PER_LED);
         3'd3:    rd_mux = mem[ptr_q];
         3'd4:    rd_mux = count_q;
         default: rd_mux = 8'd0;
      endcase
   end

   // Frame buffer; the engine port forwards a same-cycle bus write so
   // a byte written just before its fetch is sent with the new value.
   always_ff @(posedge i_clk) begin
      if (wr_data)
         mem[ptr_q] <= bus.i_data;
      rd_q <= (wr_data && ptr_q == eng_q) ? bus.i_data : mem[eng_q];
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         auto_q     <= 1'b0;
         div_q      <= 8'(CLOCK_DIV_DEFAULT);
         count_q    <= 8'd0;
         ptr_q      <= '0;
         bus.o_data <= 8'd0;
      end else begin
         if (wr) begin
            case (bus.i_addr)
               3'd0:    auto_q  <= bus.i_data[1];
               3'd1:    div_q   <= bus.i_data;
               3'd2:    ptr_q   <= idx_ptr;
               3'd3:    ptr_q   <= ptr_wrap;
               3'd4:    count_q <= bus.i_data;
               default: ;
            endcase
         end
         if (rd)
            bus.o_data <= rd_mux;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: if (ld_ph_q) state_d = HIGH;
         HIGH: if (hi_end) state_d = LOW;
         LOW: begin
            if (lo_end)
               state_d = (bit_q == 3'd0 && last_q) ? GAP : HIGH;
         end
         // Byte 0 is already prefetched, so a repeat skips the
         // LOAD pause and the gap stays exactly RESET_TICKS.
         GAP: if (gap_end) state_d = auto_q ? HIGH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         o_led_data <= 1'b0;
         o_busy     <= 1'b0;
         ld_ph_q    <= 1'b0;
         pre_q      <= 8'd0;
         tcnt_q     <= '0;
         eng_q      <= '0;
         last_q     <= 1'b0;
         bit_q      <= 3'd0;
         sh_q       <= 8'd0;
         div_f      <= 8'd0;
         nb_f       <= '0;
      end else begin
         state_q    <= state_d;
         o_led_data <= state_d == HIGH;
         o_busy     <= state_d != IDLE;
         // LOAD spends one cycle for the RAM read, one to take it.
         ld_ph_q    <= state_q == LOAD && !ld_ph_q;

         if (start || (gap_end && auto_q)) begin
            div_f <= div_q;
            nb_f  <= nb_cfg;
         end
         if (start)
            eng_q <= '0;

         if (state_q inside {HIGH, LOW, GAP} && !tick)
            pre_q <= pre_q + 8'd1;
         else
            pre_q <= 8'd0;

         if (state_d != state_q)
            tcnt_q <= '0;
         else
            tcnt_q <= tcnt_q + TW'(tick);

         if (fetch) begin
            sh_q   <= rd_q;
            bit_q  <= 3'd7;
            last_q <= last_nx;
            eng_q  <= last_nx ? '0 : eng_q + AW'(1);
         end else if (lo_end) begin
            sh_q  <= sh_q << 1;
            bit_q <= bit_q - 3'd1;
         end
      end
   end
endmodule
